// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings
// and the bit-counter width helper.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter must reach WIDTH without wrapping, so it needs clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full-adder cell shared across all bit positions of the serial adder,
// composed of two half adders and an OR for the carry.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.x(a),  .y(b),  .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

    assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: accepts an operand pair, adds it LSB-first through
// one shared full-adder cell, and holds {cout,sum} until the sink takes it.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;

    serial_fa_cell u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; built without part-selects so WIDTH=1 is legal.
    always_comb begin
        sum_next            = sum_sr >> 1;
        sum_next[WIDTH-1]   = fa_s;
    end

    // Depends on state only, never on in_valid, so the source sees no combinational loop.
    assign in_ready = (state == S_IDLE);

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // flop samples pre-edge values, matching the hardware behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sr <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end
                end

                S_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_co;
                    sum_sr <= sum_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum       <= sum_next;
                        cout      <= fa_co;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Result held until consumed; no new operands in the same cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
